// File: rtl/cnn_pkg.sv
// Shared UART/CNN constants and the transmitter state type; the receive side uses the same clock/baud values.
package cnn_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int UART_DATA_BITS   = 8;
  localparam int CLK_HZ           = 50_000_000;
  localparam int BAUD             = 115200;
  localparam int BAUD_DIV_DEFAULT = CLK_HZ / BAUD;
endpackage

// File: rtl/cnn_uart_tx_if.sv
// Result-byte push port from cnn_core plus the serial line and status flags of the transmitter.
interface cnn_uart_tx_if;
  import cnn_pkg::*;

  logic                      trmt;
  logic [UART_DATA_BITS-1:0] tx_data;
  logic                      TX;
  logic                      tx_done;
  logic                      bsy;
  logic                      full;
  logic                      ovf;

  modport master (output trmt, tx_data, input TX, tx_done, bsy, full, ovf);
  modport slave  (input trmt, tx_data, output TX, tx_done, bsy, full, ovf);
endinterface

// File: rtl/cnn_tx_fifo.sv
// Small synchronous FIFO for result bytes; head is read combinationally, no write-to-read bypass.
module cnn_tx_fifo
  import cnn_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = UART_DATA_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Storage is not reset: emptiness is tracked purely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(push) - CW'(pop);
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
endmodule

// File: rtl/cnn_uart_tx.sv
// Result-side 8N1 UART transmitter: buffers bytes from cnn_core, serializes LSB-first, pulses tx_done per byte.
module cnn_uart_tx
  import cnn_pkg::*;
#(
  parameter int BAUD_DIV   = BAUD_DIV_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  cnn_uart_tx_if.slave  bus
);
  localparam int             BW        = $clog2(BAUD_DIV);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [2:0]     BIT_LAST  = 3'(UART_DATA_BITS - 1);

  tx_state_t                 r_state;
  logic [BW-1:0]             r_baud_cnt;
  logic [2:0]                r_bit_cnt;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_tx;
  logic                      r_tx_done;
  logic                      r_ovf;

  logic                      w_empty;
  logic                      w_full;
  logic                      w_pop;
  logic                      w_push;
  logic                      w_baud_end;
  logic [UART_DATA_BITS-1:0] w_head;

  assign w_pop      = (r_state == IDLE) && !w_empty;
  assign w_push     = bus.trmt && (!w_full || w_pop);
  assign w_baud_end = (r_baud_cnt == BAUD_LAST);

  cnn_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (bus.tx_data),
    .dout  (w_head),
    .empty (w_empty),
    .full  (w_full)
  );

  // r_tx is loaded with the next line level on each transition so TX stays a flop output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_tx_done  <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      if (bus.trmt && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift    <= w_head;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= 1'b0;
            r_state    <= START;
          end
        end
        START: begin
          if (w_baud_end) begin
            r_baud_cnt <= '0;
            r_tx       <= r_shift[0];
            r_state    <= DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + BW'(1);
          end
        end
        DATA: begin
          if (w_baud_end) begin
            r_baud_cnt <= '0;
            if (r_bit_cnt == BIT_LAST) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + BW'(1);
          end
        end
        STOP: begin
          if (w_baud_end) begin
            r_baud_cnt <= '0;
            r_tx_done  <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_baud_cnt <= r_baud_cnt + BW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.TX      = r_tx;
  assign bus.tx_done = r_tx_done;
  assign bus.ovf     = r_ovf;
  assign bus.full    = w_full;
  assign bus.bsy     = (r_state != IDLE) || !w_empty;
endmodule

// File: tb/tb_cnn_uart_tx.sv
// Bench for cnn_uart_tx: frame-timeline reference model compared every cycle, a line decoder,
// directed scenarios with literal expectations, then a randomized push phase.
module tb_cnn_uart_tx;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * DIV;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cnn_uart_tx_if ifc ();

  cnn_uart_tx #(.BAUD_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_checks = 0;
  int n_errs   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errs++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference model: a byte queue plus a frame timeline (elapsed cycles since TX fell).
  logic [7:0] mq[$];
  logic [7:0] exp_rx[$];
  logic [7:0] m_cur;
  bit         m_active, m_done, m_ovf, m_tx, m_bsy, m_full;
  bit         mp_pop, mp_acc;
  int         m_t;

  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return d[idx-1];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_active = 1'b0;
      m_done   = 1'b0;
      m_ovf    = 1'b0;
      m_t      = 0;
      m_cur    = '0;
    end else begin
      mp_pop = !m_active && (mq.size() != 0);
      mp_acc = ifc.trmt && ((mq.size() < DEPTH) || mp_pop);
      if (ifc.trmt && !mp_acc) m_ovf = 1'b1;
      m_done = 1'b0;
      if (m_active) begin
        m_t++;
        if (m_t == FRAME) begin
          m_active = 1'b0;
          m_done   = 1'b1;
          exp_rx.push_back(m_cur);
        end
      end
      if (mp_pop) begin
        m_cur    = mq.pop_front();
        m_active = 1'b1;
        m_t      = 0;
      end
      if (mp_acc) mq.push_back(ifc.tx_data);
    end
    m_tx   = m_active ? frame_bit(m_cur, m_t / DIV) : 1'b1;
    m_bsy  = m_active || (mq.size() != 0);
    m_full = (mq.size() == DEPTH);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_TX", ifc.TX, m_tx);
      check("model_tx_done", ifc.tx_done, m_done);
      check("model_bsy", ifc.bsy, m_bsy);
      check("model_full", ifc.full, m_full);
      check("model_ovf", ifc.ovf, m_ovf);
    end
  end

  int cyc = 0;
  int done_times[$];
  always @(negedge clk) begin
    cyc++;
    if (ifc.tx_done === 1'b1) done_times.push_back(cyc);
  end

  // Line decoder: samples mid-bit from the first low cycle; a frame cut by reset is discarded.
  logic [7:0] rx_q[$];
  logic [7:0] dec_b;
  bit         dec_abort;
  int         stop_errs = 0;
  always begin
    @(negedge clk);
    if (chk_en && !rst && ifc.TX === 1'b0) begin
      dec_abort = 1'b0;
      dec_b     = '0;
      for (int k = 1; k <= 38; k++) begin
        @(negedge clk);
        if (rst) begin
          dec_abort = 1'b1;
          break;
        end
        if (k >= 6 && k <= 34 && ((k - 6) % 4) == 0) dec_b[(k-6)/4] = ifc.TX;
        if (k == 38 && ifc.TX !== 1'b1) stop_errs++;
      end
      if (!dec_abort) rx_q.push_back(dec_b);
    end
  end

  task automatic push(input logic [7:0] d);
    ifc.trmt    = 1'b1;
    ifc.tx_data = d;
    @(posedge clk);
    #1;
    ifc.trmt = 1'b0;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    rx_q.delete();
    exp_rx.delete();
    done_times.delete();
  endtask

  task automatic wait_tx_low(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ifc.TX === 1'b0) begin
        ok = 1'b1;
        return;
      end
    end
    timeout_fail("wait_tx_low");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (ifc.bsy === 1'b0) begin
        repeat (2) @(negedge clk);
        return;
      end
    end
    timeout_fail("wait_idle");
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ifc.tx_done === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
    timeout_fail("wait_done");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  logic [9:0] pat;
  logic [7:0] bytes[6];
  bit         ok;
  int         n_bad, n_done0;

  initial begin
    rst         = 1'b1;
    ifc.trmt    = 1'b0;
    ifc.tx_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;

    // Reset state and idle line
    @(negedge clk);
    check("rst_TX", ifc.TX, 1);
    check("rst_bsy", ifc.bsy, 0);
    check("rst_full", ifc.full, 0);
    check("rst_ovf", ifc.ovf, 0);
    check("rst_tx_done", ifc.tx_done, 0);
    n_bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (ifc.TX !== 1'b1) n_bad++;
    end
    check("idle_tx_low_cycles", n_bad, 0);
    check("idle_done_pulses", done_times.size(), 0);

    // Single byte 8'hA5: start, 1,0,1,0,0,1,0,1, stop
    pat = 10'b1101001010;
    push(8'hA5);
    wait_tx_low(ok);
    if (ok) begin
      n_bad = 0;
      for (int i = 0; i < FRAME; i++) begin
        if (i > 0) @(negedge clk);
        if ((i % DIV) == 2) check($sformatf("a5_bit%0d", i / DIV), ifc.TX, pat[i/DIV]);
        if (ifc.tx_done !== 1'b0) n_bad++;
      end
      check("a5_early_done", n_bad, 0);
      @(negedge clk);
      check("a5_done_at_40", ifc.tx_done, 1);
      check("a5_bsy_low", ifc.bsy, 0);
    end
    wait_idle();
    check("a5_decoded", rx_q.size() > 0 ? rx_q[0] : 32'hDEAD, 8'hA5);

    // Back-to-back frames
    rx_q.delete();
    done_times.delete();
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    wait_idle();
    check("b2b_count", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      check("b2b_byte0", rx_q[0], 8'h00);
      check("b2b_byte1", rx_q[1], 8'hFF);
      check("b2b_byte2", rx_q[2], 8'h3C);
    end
    check("b2b_done_count", done_times.size(), 3);
    if (done_times.size() == 3) begin
      check("b2b_gap01", done_times[1] - done_times[0], 41);
      check("b2b_gap12", done_times[2] - done_times[1], 41);
    end

    // Overflow: six pushes in a row, the sixth is dropped
    rx_q.delete();
    done_times.delete();
    for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) push(bytes[i]);
    @(negedge clk);
    check("ovf_full", ifc.full, 1);
    check("ovf_flag", ifc.ovf, 1);
    wait_idle();
    check("ovf_sticky", ifc.ovf, 1);
    check("ovf_frames", rx_q.size(), 5);
    if (rx_q.size() == 5)
      for (int i = 0; i < 5; i++) check($sformatf("ovf_byte%0d", i), rx_q[i], bytes[i]);

    // Push in the IDLE pop cycle while full
    rst_pulse();
    for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
    for (int i = 0; i < 5; i++) push(bytes[i]);
    wait_done(ok);
    if (ok) begin
      check("pop_push_full_before", ifc.full, 1);
      push(bytes[5]);
      @(negedge clk);
      check("pop_push_full_after", ifc.full, 1);
      check("pop_push_no_ovf", ifc.ovf, 0);
    end
    wait_idle();
    check("pop_push_frames", rx_q.size(), 6);
    if (rx_q.size() == 6)
      for (int i = 0; i < 6; i++) check($sformatf("pop_push_byte%0d", i), rx_q[i], bytes[i]);
    check("pop_push_ovf_end", ifc.ovf, 0);

    // Reset during data bit 3 of 8'h5A
    rst_pulse();
    push(8'h5A);
    wait_tx_low(ok);
    if (ok) begin
      repeat (4 + 4 * 3 + 1) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_TX", ifc.TX, 1);
      check("midrst_bsy", ifc.bsy, 0);
      check("midrst_full", ifc.full, 0);
      check("midrst_tx_done", ifc.tx_done, 0);
      rst = 1'b0;
    end
    n_done0 = done_times.size();
    rx_q.delete();
    push(8'h81);
    wait_idle();
    check("midrst_done_count", done_times.size() - n_done0, 1);
    check("midrst_next_byte", rx_q.size() == 1 ? rx_q[0] : 32'hDEAD, 8'h81);

    // Randomized pushes with varying density
    rst_pulse();
    for (int i = 0; i < 1200; i++) begin
      ifc.trmt    = ($urandom_range(0, (i < 600) ? 15 : 3) == 0);
      ifc.tx_data = 8'($urandom);
      @(posedge clk);
      #1;
    end
    ifc.trmt = 1'b0;
    wait_idle();
    check("rand_frame_count", rx_q.size(), exp_rx.size());
    if (rx_q.size() == exp_rx.size())
      for (int i = 0; i < rx_q.size(); i++) check($sformatf("rand_byte%0d", i), rx_q[i], exp_rx[i]);
    check("stop_bit_errors", stop_errs, 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
